// File: rtl/fetcher_pkg.sv
// fetcher_pkg: core-state and fetch-state encodings shared by the fetch stage and its users
package fetcher_pkg;

    typedef enum logic [2:0] {
        SIMD_IDLE    = 3'd0,
        SIMD_FETCH   = 3'd1,
        SIMD_DECODE  = 3'd2,
        SIMD_REQUEST = 3'd3,
        SIMD_WAIT    = 3'd4,
        SIMD_EXECUTE = 3'd5,
        SIMD_UPDATE  = 3'd6,
        SIMD_DONE    = 3'd7
    } simd_state_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUSY = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetcher.sv
// fetcher: instruction fetch stage issuing one valid/ready program-memory read per SIMD_FETCH
// Optional one-entry pc cache enabled by defining FETCHER_PC_CACHE_EN.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int PROGRAM_ADDR_WIDTH = 8,
    parameter int INSTRUCTION_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    simd_state,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] pc,
    output logic                          mem_read_valid,
    output logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic                          mem_read_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]  mem_read_data,
    output logic [1:0]                    fetcher_state,
    output logic [INSTRUCTION_WIDTH-1:0]  instruction
);

    fetch_state_t                  state_q, state_d;
    logic                          valid_q, valid_d;
    logic [PROGRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTRUCTION_WIDTH-1:0]  instr_q, instr_d;
    logic                          hit;
    logic                          capture;

`ifdef FETCHER_PC_CACHE_EN
    logic [PROGRAM_ADDR_WIDTH-1:0] cached_pc_q;
    logic                          cache_valid_q;

    assign hit = cache_valid_q && (pc == cached_pc_q);

    // Remember the address of the most recent memory capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cached_pc_q   <= '0;
            cache_valid_q <= 1'b0;
        end else if (capture) begin
            cached_pc_q   <= addr_q;
            cache_valid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign capture = (state_q == FETCH_BUSY) && mem_read_ready;

    // Next-state and registered-output logic of the fetch FSM
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            FETCH_IDLE: begin
                if (enable && simd_state == SIMD_FETCH) begin
                    if (hit) begin
                        state_d = FETCH_DONE;
                    end else begin
                        state_d = FETCH_BUSY;
                        valid_d = 1'b1;
                        addr_d  = pc;
                    end
                end
            end
            FETCH_BUSY: begin
                if (mem_read_ready) begin
                    state_d = FETCH_DONE;
                    valid_d = 1'b0;
                    instr_d = mem_read_data;
                end
            end
            FETCH_DONE: begin
                if (simd_state == SIMD_DECODE) state_d = FETCH_IDLE;
            end
            default: begin
                state_d = FETCH_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset drops any in-flight request at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;

endmodule
